pipeline_hazard_unit: RTL and testbench
=======================================

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 SHALL have parameter FWD_DEPTH, default 2, meaning the number of post-EX stages that can forward; slot 1 is MEM, slot 2 is WB.
REQ-002 SHALL have parameter LOAD_USE_DEPTH, default 1, meaning the number of scoreboard slots in which a load result is not yet forwardable.
REQ-003 SHALL have parameter BRANCH_SLOT, default 1, meaning the scoreboard slot holding a branch when branch_taken is asserted; 1 is MEM.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, meaning the width of the performance counters.
REQ-005 SHALL have clk, input, 1 bit: the single clock.
REQ-006 SHALL have reset, input, 1 bit: the reset, which is synchronous and active-low.
REQ-007 SHALL have id_valid, input, 1 bit: the IF/ID register holds a real instruction.
REQ-008 SHALL have id_rs and id_rt, input, 5 bits each: the source registers of the ID instruction.
REQ-009 SHALL have id_uses_rs and id_uses_rt, input, 1 bit each: the corresponding source is actually read.
REQ-010 SHALL have id_dest, input, 5 bits: the destination register, already muxed for RegDst and jal (31).
REQ-011 SHALL have id_reg_write and id_mem_read, input, 1 bit each: the ID control bits.
REQ-012 SHALL have branch_taken, input, 1 bit: the branch in slot BRANCH_SLOT redirects the PC this cycle.
REQ-013 SHALL have jump_id, input, 1 bit: j, jal or jr is decoded in ID and redirects the PC this cycle.
REQ-014 SHALL have pc_enable and if_id_enable, output, 1 bit each: the hold controls for the PC and IF/ID.
REQ-015 SHALL have flush, output, BRANCH_SLOT+2 bits: bit0 clears IF/ID, bit1 clears ID/EX, bit k clears the slot k-1 register.
REQ-016 SHALL have fwd_sel_a and fwd_sel_b, output, clog2(FWD_DEPTH+1) bits: the EX operand source, 0 for the register file and k for slot k.
REQ-017 SHALL have stall_count and flush_count, output, CNT_WIDTH bits each: saturating event counters.

Function
REQ-018 SHALL keep a scoreboard sb[0..FWD_DEPTH], where sb[0] is EX, with entries {valid, dest, reg_write, is_load}.
REQ-019 SHALL shift the scoreboard every cycle.
REQ-020 SHALL load sb[0] with the ID instruction when it advances (id_valid, no stall, no flush), and with an invalid entry otherwise.
REQ-021 SHALL treat an entry as matching a source when valid & reg_write & dest==src & src!=0 & the source is used.
REQ-022 SHALL declare a load-use hazard when a matching entry has is_load=1 in slot k < LOAD_USE_DEPTH.
REQ-023 On a load-use hazard, SHALL drive pc_enable=0, if_id_enable=0 and flush[1]=1 (bubble) in the same cycle.
REQ-024 SHALL stall for exactly as many cycles as the hazard persists, i.e. LOAD_USE_DEPTH cycles for a load-to-consumer gap of zero.
REQ-025 SHALL register fwd_sel for each source so it is valid while the instruction is in EX (one cycle after ID).
REQ-026 SHALL select, for an ID-time match in slot k, k+1 if k+1 <= FWD_DEPTH and 0 otherwise; when several slots match, the youngest (lowest k) wins.
REQ-027 SHALL treat a producer in slot FWD_DEPTH as resolved by register-file write-through, giving fwd_sel 0.
REQ-028 When the ID instruction does not advance, SHALL force fwd_sel to 0 next cycle.
REQ-029 On branch_taken, SHALL assert flush[BRANCH_SLOT+1:0] all ones in the same cycle and keep pc_enable=1 for the redirect.
REQ-030 On branch_taken, SHALL invalidate the next sb[0..BRANCH_SLOT]; any stall is suppressed.
REQ-031 On jump_id without branch_taken, SHALL assert flush[0] only, and the ID instruction advances normally.
REQ-032 SHALL give priority reset > branch_taken > load-use stall > jump_id.
REQ-033 SHALL increment stall_count once per stall cycle and flush_count once per branch_taken or jump_id cycle.
REQ-034 SHALL hold each counter at all-ones once reached.

Reset
REQ-035 SHALL, while reset=0 at a clk edge, clear all sb entries to invalid, set fwd_sel to 0 and set both counters to 0.
REQ-036 SHALL drive pc_enable=1, if_id_enable=1 and flush all ones while reset=0.
REQ-037 Reset asserted mid-stall or mid-flush SHALL abandon the event; the first cycle after release shows no hazard.

Structure
REQ-038 SHALL take the fwd_sel encoding constants and the scoreboard entry typedef from shared package pipeline_pkg.
REQ-039 SHALL use one sub-module, hazard_match, which compares one source against all slots and returns the match vector; it is instantiated once per source.

Verification
REQ-040 SHALL cover: add $3 then add $4,$3,$5 back-to-back -> fwd_sel_a=1 in the consumer's EX cycle, with no stall.
REQ-041 SHALL cover: lw $2 then add $6,$2,$2 -> one cycle with pc_enable=0 and flush[1]=1, then fwd_sel_a=fwd_sel_b=2, and stall_count=1.
REQ-042 SHALL cover: add $3 with a one-instruction gap, then sub $7,$1,$3 -> fwd_sel_b=2.
REQ-043 SHALL cover: writes to $0 followed by readers -> fwd_sel always 0 and no stall.
REQ-044 SHALL cover: branch_taken in the same cycle as a load-use hazard -> flush=3'b111, no stall, flush_count=1, and stall_count unchanged.
REQ-045 SHALL cover: reset=0 asserted during a stall with LOAD_USE_DEPTH=2 -> next cycle counters are 0, all sb entries are invalid, and pc_enable=1 after release.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the hazard unit: scoreboard entry layout and the
// forwarding-select encoding.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         FWD_RF   = 0;  // operand from the register file
  localparam int         FWD_MEM  = 1;
  localparam int         FWD_WB   = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       reg_write;
    logic       is_load;
  } sb_entry_t;

  // A producer seen in slot k at ID time sits in slot k+1 once the consumer
  // reaches EX; past the last forwarding slot the register file has it.
  function automatic int fwd_code(input int slot, input int depth);
    return (slot + 1 <= depth) ? slot + 1 : FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle between the pipeline
// (master) and the hazard unit (slave).
interface pipeline_hazard_unit_if #(
  parameter int FWD_DEPTH   = 2,
  parameter int BRANCH_SLOT = 1,
  parameter int CNT_WIDTH   = 32
);
  localparam int SW = $clog2(FWD_DEPTH + 1);

  logic                   id_valid;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic [4:0]             id_dest;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic                   branch_taken;
  logic                   jump_id;
  logic                   pc_enable;
  logic                   if_id_enable;
  logic [BRANCH_SLOT+1:0] flush;
  logic [SW-1:0]          fwd_sel_a;
  logic [SW-1:0]          fwd_sel_b;
  logic [CNT_WIDTH-1:0]   stall_count;
  logic [CNT_WIDTH-1:0]   flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, branch_taken, jump_id,
    input  pc_enable, if_id_enable, flush, fwd_sel_a, fwd_sel_b,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, branch_taken, jump_id,
    output pc_enable, if_id_enable, flush, fwd_sel_a, fwd_sel_b,
           stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_unit_match.sv
// Compares one ID source register against every scoreboard slot; also flags
// a load result that is still too young to forward.
module hazard_match
  import pipeline_pkg::*;
#(
  parameter int NUM_SLOTS      = 3,
  parameter int LOAD_USE_DEPTH = 1
) (
  input  logic [4:0]                  src,
  input  logic                        used,
  input  sb_entry_t [NUM_SLOTS-1:0]   slots,
  output logic [NUM_SLOTS-1:0]        match,
  output logic                        load_use
);

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign match[k] = used && (src != REG_ZERO) && slots[k].valid &&
                      slots[k].reg_write && (slots[k].dest == src);
  end

  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (k < LOAD_USE_DEPTH && match[k] && slots[k].is_load) load_use = 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, EX operand forwarding select and branch/jump flush control
// driven from a shifting scoreboard of in-flight destinations.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int FWD_DEPTH      = 2,
  parameter int LOAD_USE_DEPTH = 1,
  parameter int BRANCH_SLOT    = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_unit_if.slave hz
);
   localparam int NSLOT = FWD_DEPTH + 1;
   localparam int SW    = $clog2(FWD_DEPTH + 1);

   sb_entry_t [NSLOT-1:0]   sb;
   sb_entry_t               sb_in;
   logic [1:0][4:0]         src;
   logic [1:0]              src_used;
   logic [1:0][NSLOT-1:0]   match;
   logic [1:0]              load_use;
   logic [1:0][SW-1:0]      sel_d;
   logic [1:0][SW-1:0]      sel_q;
   logic                    stall;
   logic                    advance;
   logic                    flush_ev;
   logic [CNT_WIDTH-1:0]    stall_cnt;
   logic [CNT_WIDTH-1:0]    flush_cnt;

   assign src      = {hz.id_rt, hz.id_rs};
   assign src_used = {hz.id_uses_rt & hz.id_valid, hz.id_uses_rs & hz.id_valid};

   for (genvar g = 0; g < 2; g++) begin : g_src
      hazard_match #(.NUM_SLOTS(NSLOT), .LOAD_USE_DEPTH(LOAD_USE_DEPTH)) u_match (
         .src      (src[g]),
         .used     (src_used[g]),
         .slots    (sb),
         .match    (match[g]),
         .load_use (load_use[g])
      );
   end

   // Walk oldest to youngest so the lowest matching slot has the last word.
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         sel_d[g] = SW'(FWD_RF);
         for (int k = NSLOT - 1; k >= 0; k--)
            if (match[g][k]) sel_d[g] = SW'(fwd_code(k, FWD_DEPTH));
      end
   end

   assign stall   = (|load_use) & ~hz.branch_taken;
   assign advance = hz.id_valid & ~stall & ~hz.branch_taken;
   // A jump held behind a stall has not redirected yet, so it is not counted.
   assign flush_ev = hz.branch_taken | (hz.jump_id & ~stall);

   always_comb begin
      sb_in           = '0;
      sb_in.valid     = advance;
      sb_in.dest      = hz.id_dest;
      sb_in.reg_write = hz.id_reg_write;
      sb_in.is_load   = hz.id_mem_read;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sb        <= '0;
         sel_q     <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         for (int k = NSLOT - 1; k >= 1; k--) begin
            if (hz.branch_taken && k <= BRANCH_SLOT) sb[k] <= '0;
            else                                     sb[k] <= sb[k-1];
         end
         sb[0] <= advance ? sb_in : '0;
         for (int g = 0; g < 2; g++) sel_q[g] <= advance ? sel_d[g] : SW'(FWD_RF);
         if (stall && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
         if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   always_comb begin
      hz.pc_enable    = 1'b1;
      hz.if_id_enable = 1'b1;
      hz.flush        = '0;
      if (!reset) begin
         hz.flush = '1;
      end else if (hz.branch_taken) begin
         hz.flush = '1;
      end else if (stall) begin
         hz.pc_enable    = 1'b0;
         hz.if_id_enable = 1'b0;
         hz.flush[1]     = 1'b1;
      end else if (hz.jump_id) begin
         hz.flush[0] = 1'b1;
      end
   end

   assign hz.fwd_sel_a   = sel_q[0];
   assign hz.fwd_sel_b   = sel_q[1];
   assign hz.stall_count = stall_cnt;
   assign hz.flush_count = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed checks of forwarding, load-use stalls, flushes and reset, using a
// default instance and one with a two-slot load-use window.
module tb_pipeline_hazard_unit;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   pipeline_hazard_unit_if #(.FWD_DEPTH(2), .BRANCH_SLOT(1), .CNT_WIDTH(32)) ifa ();
   pipeline_hazard_unit_if #(.FWD_DEPTH(2), .BRANCH_SLOT(1), .CNT_WIDTH(32)) ifb ();

   pipeline_hazard_unit #(.FWD_DEPTH(2), .LOAD_USE_DEPTH(1), .BRANCH_SLOT(1), .CNT_WIDTH(32))
      u_dut (.clk(clk), .reset(reset), .hz(ifa));
   pipeline_hazard_unit #(.FWD_DEPTH(2), .LOAD_USE_DEPTH(2), .BRANCH_SLOT(1), .CNT_WIDTH(32))
      u_dut2 (.clk(clk), .reset(reset), .hz(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit rw, input bit mr);
      ifa.id_valid = v; ifa.id_rs = 5'(rs); ifa.id_rt = 5'(rt);
      ifa.id_uses_rs = urs; ifa.id_uses_rt = urt; ifa.id_dest = 5'(dest);
      ifa.id_reg_write = rw; ifa.id_mem_read = mr;
   endtask

   task automatic drv_b(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit rw, input bit mr);
      ifb.id_valid = v; ifb.id_rs = 5'(rs); ifb.id_rt = 5'(rt);
      ifb.id_uses_rs = urs; ifb.id_uses_rt = urt; ifb.id_dest = 5'(dest);
      ifb.id_reg_write = rw; ifb.id_mem_read = mr;
   endtask

   task automatic nops(input int n);
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);
      ifa.branch_taken = 0; ifa.jump_id = 0; ifb.branch_taken = 0; ifb.jump_id = 0;
      @(negedge clk);
      checks++; if (ifa.flush !== 3'b111) begin errors++; $display("FAIL rst_flush got %b want 111", ifa.flush); end
      checks++; if (ifa.pc_enable !== 1'b1 || ifa.if_id_enable !== 1'b1) begin errors++; $display("FAIL rst_enables got %b%b want 11", ifa.pc_enable, ifa.if_id_enable); end
      cyc(); cyc();
      @(negedge clk);
      checks++; if (ifa.fwd_sel_a !== 2'd0 || ifa.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d want 0/0", ifa.fwd_sel_a, ifa.fwd_sel_b); end
      checks++; if (ifa.stall_count !== 0 || ifa.flush_count !== 0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", ifa.stall_count, ifa.flush_count); end
      cyc();
      reset = 1'b1;
      nops(1);
   endtask

   task automatic test_back_to_back();
      drv_a(1, 1, 2, 1, 1, 3, 1, 0);              // add $3,$1,$2
      cyc();
      drv_a(1, 3, 5, 1, 1, 4, 1, 0);              // add $4,$3,$5
      @(negedge clk);
      checks++; if (ifa.pc_enable !== 1'b1 || ifa.flush !== 3'b000) begin errors++; $display("FAIL b2b_nostall got pc=%b flush=%b want 1/000", ifa.pc_enable, ifa.flush); end
      cyc();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ifa.fwd_sel_a !== 2'd1 || ifa.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL b2b_fwd got %0d/%0d want 1/0", ifa.fwd_sel_a, ifa.fwd_sel_b); end
      nops(3);
   endtask

   task automatic test_load_use();
      drv_a(1, 1, 0, 1, 0, 2, 1, 1);              // lw $2,0($1)
      cyc();
      drv_a(1, 2, 2, 1, 1, 6, 1, 0);              // add $6,$2,$2
      @(negedge clk);
      checks++; if (ifa.pc_enable !== 1'b0 || ifa.if_id_enable !== 1'b0 || ifa.flush !== 3'b010) begin errors++; $display("FAIL lu_stall got pc=%b ifid=%b flush=%b want 0/0/010", ifa.pc_enable, ifa.if_id_enable, ifa.flush); end
      cyc();
      @(negedge clk);
      checks++; if (ifa.pc_enable !== 1'b1 || ifa.flush !== 3'b000) begin errors++; $display("FAIL lu_release got pc=%b flush=%b want 1/000", ifa.pc_enable, ifa.flush); end
      checks++; if (ifa.fwd_sel_a !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd got %0d want 0", ifa.fwd_sel_a); end
      cyc();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ifa.fwd_sel_a !== 2'd2 || ifa.fwd_sel_b !== 2'd2) begin errors++; $display("FAIL lu_fwd got %0d/%0d want 2/2", ifa.fwd_sel_a, ifa.fwd_sel_b); end
      checks++; if (ifa.stall_count !== 32'd1) begin errors++; $display("FAIL lu_count got %0d want 1", ifa.stall_count); end
      nops(3);
   endtask

   task automatic test_gap();
      drv_a(1, 1, 2, 1, 1, 3, 1, 0);              // add $3
      cyc();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      drv_a(1, 1, 3, 1, 1, 7, 1, 0);              // sub $7,$1,$3
      @(negedge clk);
      checks++; if (ifa.pc_enable !== 1'b1) begin errors++; $display("FAIL gap_nostall got %b want 1", ifa.pc_enable); end
      cyc();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ifa.fwd_sel_a !== 2'd0 || ifa.fwd_sel_b !== 2'd2) begin errors++; $display("FAIL gap_fwd got %0d/%0d want 0/2", ifa.fwd_sel_a, ifa.fwd_sel_b); end
      nops(3);
   endtask

   task automatic test_zero_reg();
      drv_a(1, 1, 2, 1, 1, 0, 1, 0);              // add $0,$1,$2
      cyc();
      drv_a(1, 0, 0, 1, 1, 5, 1, 0);              // add $5,$0,$0
      @(negedge clk);
      checks++; if (ifa.pc_enable !== 1'b1) begin errors++; $display("FAIL zero_nostall1 got %b want 1", ifa.pc_enable); end
      cyc();
      drv_a(1, 1, 0, 1, 0, 0, 1, 1);              // lw $0,0($1)
      @(negedge clk);
      checks++; if (ifa.fwd_sel_a !== 2'd0 || ifa.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL zero_fwd1 got %0d/%0d want 0/0", ifa.fwd_sel_a, ifa.fwd_sel_b); end
      cyc();
      drv_a(1, 0, 0, 1, 1, 6, 1, 0);              // add $6,$0,$0
      @(negedge clk);
      checks++; if (ifa.pc_enable !== 1'b1 || ifa.flush !== 3'b000) begin errors++; $display("FAIL zero_nostall2 got pc=%b flush=%b want 1/000", ifa.pc_enable, ifa.flush); end
      cyc();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ifa.fwd_sel_a !== 2'd0 || ifa.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL zero_fwd2 got %0d/%0d want 0/0", ifa.fwd_sel_a, ifa.fwd_sel_b); end
      checks++; if (ifa.stall_count !== 32'd1) begin errors++; $display("FAIL zero_stallcnt got %0d want 1", ifa.stall_count); end
      nops(3);
   endtask

   task automatic test_branch_over_stall();
      drv_a(1, 1, 0, 1, 0, 2, 1, 1);              // lw $2
      cyc();
      drv_a(1, 2, 2, 1, 1, 6, 1, 0);              // add $6,$2,$2 with branch in MEM
      ifa.branch_taken = 1'b1;
      @(negedge clk);
      checks++; if (ifa.flush !== 3'b111 || ifa.pc_enable !== 1'b1 || ifa.if_id_enable !== 1'b1) begin errors++; $display("FAIL br_flush got flush=%b pc=%b ifid=%b want 111/1/1", ifa.flush, ifa.pc_enable, ifa.if_id_enable); end
      cyc();
      ifa.branch_taken = 1'b0;
      @(negedge clk);
      checks++; if (ifa.flush_count !== 32'd1 || ifa.stall_count !== 32'd1) begin errors++; $display("FAIL br_counts got flush=%0d stall=%0d want 1/1", ifa.flush_count, ifa.stall_count); end
      checks++; if (ifa.pc_enable !== 1'b1) begin errors++; $display("FAIL br_load_squashed got pc=%b want 1", ifa.pc_enable); end
      nops(3);
   endtask

   task automatic test_jump();
      drv_a(1, 0, 0, 0, 0, 31, 1, 0);             // jal -> $31
      ifa.jump_id = 1'b1;
      @(negedge clk);
      checks++; if (ifa.flush !== 3'b001 || ifa.pc_enable !== 1'b1 || ifa.if_id_enable !== 1'b1) begin errors++; $display("FAIL jmp_flush got flush=%b pc=%b ifid=%b want 001/1/1", ifa.flush, ifa.pc_enable, ifa.if_id_enable); end
      cyc();
      ifa.jump_id = 1'b0;
      drv_a(1, 31, 0, 1, 0, 8, 1, 0);             // add $8,$31,$0
      cyc();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ifa.fwd_sel_a !== 2'd1) begin errors++; $display("FAIL jmp_advance_fwd got %0d want 1", ifa.fwd_sel_a); end
      checks++; if (ifa.flush_count !== 32'd2) begin errors++; $display("FAIL jmp_count got %0d want 2", ifa.flush_count); end
      nops(3);
   endtask

   task automatic test_reset_mid_stall();
      drv_b(1, 1, 0, 1, 0, 2, 1, 1);              // lw $2 into the two-slot window
      cyc();
      drv_b(1, 2, 2, 1, 1, 6, 1, 0);              // add $6,$2,$2
      @(negedge clk);
      checks++; if (ifb.pc_enable !== 1'b0) begin errors++; $display("FAIL rms_stall1 got %b want 0", ifb.pc_enable); end
      cyc();
      #1;
      checks++; if (ifb.pc_enable !== 1'b0 || ifb.stall_count !== 32'd1) begin errors++; $display("FAIL rms_stall2 got pc=%b cnt=%0d want 0/1", ifb.pc_enable, ifb.stall_count); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (ifb.pc_enable !== 1'b1 || ifb.flush !== 3'b111) begin errors++; $display("FAIL rms_inreset got pc=%b flush=%b want 1/111", ifb.pc_enable, ifb.flush); end
      cyc();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (ifb.stall_count !== 0 || ifb.flush_count !== 0) begin errors++; $display("FAIL rms_cnt got %0d/%0d want 0/0", ifb.stall_count, ifb.flush_count); end
      checks++; if (ifb.pc_enable !== 1'b1 || ifb.flush !== 3'b000) begin errors++; $display("FAIL rms_nohazard got pc=%b flush=%b want 1/000", ifb.pc_enable, ifb.flush); end
      cyc();
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ifb.fwd_sel_a !== 2'd0 || ifb.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL rms_sb_empty got %0d/%0d want 0/0", ifb.fwd_sel_a, ifb.fwd_sel_b); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load_use();
      test_gap();
      test_zero_reg();
      test_branch_over_stall();
      test_jump();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
